// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_pkg
//  Description : Shared types and default sizing for the matrix-vector
//                multiply sequencer and its skew generator.
//  Revision    : 1.0  initial release
// ============================================================================
package mvm_pkg;

  // Sequencer states; IDLE is the reset state.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_FILL      = 3'd2,
    S_WAIT_FILL = 3'd3,
    S_COMPUTE   = 3'd4,
    S_DRAIN     = 3'd5,
    S_FINISH    = 3'd6
  } mvm_state_t;

  // Default array geometry.
  localparam int NUM_ROWS_DEF = 8;
  localparam int VEC_LEN_DEF  = 8;

  // Counter width able to hold the longest COMPUTE index for the defaults.
  localparam int CNT_W = $clog2(VEC_LEN_DEF + NUM_ROWS_DEF);

  // The vector (B) FIFO sits above the row FIFOs in the enable/empty vectors.
  localparam int B_IDX = NUM_ROWS_DEF;

endpackage
`default_nettype wire

// File: rtl/mvm_skew_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_skew_gen
//  Description : Systolic read-enable skew. Row FIFO i is read during COMPUTE
//                counts i .. i+VEC_LEN-1, the vector FIFO during 0..VEC_LEN-1.
//                MAC enables are the row read enables delayed one cycle to
//                line up with FIFO read data.
//  Revision    : 1.0  initial release
// ============================================================================
module mvm_skew_gen
  import mvm_pkg::*;
#(
  parameter int NUM_ROWS  = NUM_ROWS_DEF,
  parameter int VEC_LEN   = VEC_LEN_DEF,
  parameter int CNT_WIDTH = CNT_W,
  parameter int B_BIT     = B_IDX
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic                 active,
  input  logic                 hold,
  output logic [NUM_ROWS:0]    rden_req,
  output logic [NUM_ROWS:0]    rden,
  output logic [NUM_ROWS-1:0]  mac_en
);

  int cnt_i;

  assign cnt_i = {{(32-CNT_WIDTH){1'b0}}, cnt};

  // Requested read window for every FIFO at the current COMPUTE count.
  always_comb begin
    rden_req = '0;
    if (active) begin
      rden_req[B_BIT] = (cnt_i < VEC_LEN);
      for (int i = 0; i < NUM_ROWS; i++) begin
        rden_req[i] = (cnt_i >= i) && (cnt_i < i + VEC_LEN);
      end
    end
  end

  // A faulting cycle must not pop anything.
  assign rden = hold ? '0 : rden_req;

  // MAC enables follow the granted row reads by one cycle (read latency).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_en <= '0;
    end else begin
      mac_en <= rden[NUM_ROWS-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mvm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_sequencer
//  Description : Top-level controller for the matrix-vector multiply datapath.
//                Clears the MACs, launches the FIFO fill, then streams skewed
//                FIFO reads / MAC enables and reports done or underflow.
//  Revision    : 1.0  initial release
// ============================================================================
module mvm_sequencer
  import mvm_pkg::*;
#(
  parameter int NUM_ROWS   = NUM_ROWS_DEF,
  parameter int VEC_LEN    = VEC_LEN_DEF,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  fill_start,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic                  fill_done,
  input  logic [NUM_ROWS:0]     fifo_empty,
  output logic [NUM_ROWS:0]     fifo_rden,
  output logic                  mac_clr,
  output logic [NUM_ROWS-1:0]   mac_en
);

  localparam int                   CNT_WIDTH = $clog2(VEC_LEN + NUM_ROWS);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(VEC_LEN + NUM_ROWS - 2);

  mvm_state_t           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [NUM_ROWS:0]    rden_req;
  logic                 computing;
  logic                 underflow;

  assign computing = (state == S_COMPUTE);
  // Any requested read of an empty FIFO aborts the operation this cycle.
  assign underflow = computing && |(rden_req & fifo_empty);

  mvm_skew_gen #(
    .NUM_ROWS  (NUM_ROWS),
    .VEC_LEN   (VEC_LEN),
    .CNT_WIDTH (CNT_WIDTH),
    .B_BIT     (NUM_ROWS)
  ) u_skew (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .active   (computing),
    .hold     (underflow),
    .rden_req (rden_req),
    .rden     (fifo_rden),
    .mac_en   (mac_en)
  );

  // Control FSM with registered outputs. In WAIT_FILL, cnt doubles as the
  // first-cycle marker so a stale fill_done level is not taken as completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      fill_start <= 1'b0;
      fill_addr  <= '0;
      mac_clr    <= 1'b0;
    end else begin
      done       <= 1'b0;
      fill_start <= 1'b0;
      mac_clr    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            fill_addr <= base_addr;
            err       <= 1'b0;
            busy      <= 1'b1;
            mac_clr   <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          fill_start <= 1'b1;
          state      <= S_FILL;
        end
        S_FILL: begin
          cnt   <= '0;
          state <= S_WAIT_FILL;
        end
        S_WAIT_FILL: begin
          if (cnt == '0) begin
            cnt <= CNT_WIDTH'(1);
          end else if (fill_done) begin
            cnt   <= '0;
            state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (underflow) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_FINISH;
          end else if (cnt == CNT_LAST) begin
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          done  <= 1'b1;
          state <= S_FINISH;
        end
        S_FINISH: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mvm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvm_sequencer
//  Description : Scoreboard bench for mvm_sequencer. Two instances (8x8 and
//                2x3) share one harness; a FIFO occupancy model drives
//                fifo_empty and a per-operation expectation is queued at
//                issue time and checked when done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mvm_sequencer;

  typedef struct packed {
    logic            err;
    logic [31:0]     addr;
    logic [7:0]      s;       // fill_start -> first COMPUTE cycle
    logic [7:0]      fault;   // COMPUTE index of abort (NR+VL-1 when clean)
    logic [8:0][7:0] reads;   // expected pops per FIFO
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_cmd = 1'b0;
  logic [31:0] base_addr = '0;
  logic        fill_done = 1'b0;
  logic [8:0]  emp;
  bit          sel = 1'b0;
  int          cur_nr = 8;
  int          cur_vl = 8;

  logic b_busy, b_done, b_err, b_fs, b_clr;
  logic [31:0] b_fa;
  logic [8:0]  b_rden;
  logic [7:0]  b_mac;
  logic s_busy, s_done, s_err, s_fs, s_clr;
  logic [31:0] s_fa;
  logic [2:0]  s_rden;
  logic [1:0]  s_mac;
  logic start_b, start_s;

  logic o_busy, o_done, o_err, o_fs, o_clr;
  logic [31:0] o_fa;
  logic [8:0]  o_rden;
  logic [7:0]  o_mac;

  int   fcnt [9];
  int   n_load [9];
  int   load_seq = 0;
  int   load_seen = 0;
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign start_b = start_cmd & ~sel;
  assign start_s = start_cmd & sel;

  mvm_sequencer #(.NUM_ROWS(8), .VEC_LEN(8), .ADDR_WIDTH(32)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_addr),
    .busy(b_busy), .done(b_done), .err(b_err), .fill_start(b_fs),
    .fill_addr(b_fa), .fill_done(fill_done), .fifo_empty(emp),
    .fifo_rden(b_rden), .mac_clr(b_clr), .mac_en(b_mac)
  );

  mvm_sequencer #(.NUM_ROWS(2), .VEC_LEN(3), .ADDR_WIDTH(32)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .base_addr(base_addr),
    .busy(s_busy), .done(s_done), .err(s_err), .fill_start(s_fs),
    .fill_addr(s_fa), .fill_done(fill_done), .fifo_empty(emp[2:0]),
    .fifo_rden(s_rden), .mac_clr(s_clr), .mac_en(s_mac)
  );

  assign o_busy = sel ? s_busy : b_busy;
  assign o_done = sel ? s_done : b_done;
  assign o_err  = sel ? s_err  : b_err;
  assign o_fs   = sel ? s_fs   : b_fs;
  assign o_clr  = sel ? s_clr  : b_clr;
  assign o_fa   = sel ? s_fa   : b_fa;
  assign o_rden = sel ? {6'b0, s_rden} : b_rden;
  assign o_mac  = sel ? {6'b0, s_mac}  : b_mac;

  // FIFO occupancy model: bulk load from the fill engine, pop on read enable.
  always_comb begin
    for (int j = 0; j < 9; j++) emp[j] = (fcnt[j] == 0);
  end

  always @(posedge clk) begin
    if (load_seq != load_seen) begin
      for (int j = 0; j < 9; j++) fcnt[j] <= n_load[j];
      load_seen <= load_seq;
    end else begin
      for (int j = 0; j < 9; j++)
        if (o_rden[j] && fcnt[j] > 0) fcnt[j] <= fcnt[j] - 1;
    end
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_fill_start"}, o_fs, 0);
    check({tag, "_fill_addr"}, o_fa, 0);
    check({tag, "_fifo_rden"}, o_rden, 0);
    check({tag, "_mac_clr"}, o_clr, 0);
    check({tag, "_mac_en"}, o_mac, 0);
  endtask

  // Monitor: accumulate per-operation activity, compare on done.
  int cyc = 0, fs_cyc = 0, fs_count = 0, clr_cyc = 0, clr_count = 0, ebad = 0;
  int reads [9], first [9], last [9];
  int mcnt [8], mfirst [8], mlast [8];

  task automatic clear_acc();
    fs_count = 0; clr_count = 0; ebad = 0;
    for (int j = 0; j < 9; j++) begin reads[j] = 0; first[j] = 0; last[j] = 0; end
    for (int i = 0; i < 8; i++) begin mcnt[i] = 0; mfirst[i] = 0; mlast[i] = 0; end
  endtask

  initial begin
    exp_t e;
    int   off;
    clear_acc();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        clear_acc();
      end else begin
        if (o_clr) begin clr_count++; clr_cyc = cyc; end
        if (o_fs)  begin fs_count++;  fs_cyc = cyc;  end
        for (int j = 0; j < 9; j++) begin
          if (o_rden[j]) begin
            if (emp[j]) ebad++;
            else begin
              if (reads[j] == 0) first[j] = cyc - fs_cyc;
              last[j] = cyc - fs_cyc;
              reads[j]++;
            end
          end
        end
        for (int i = 0; i < 8; i++) begin
          if (o_mac[i]) begin
            if (mcnt[i] == 0) mfirst[i] = cyc - fs_cyc;
            mlast[i] = cyc - fs_cyc;
            mcnt[i]++;
          end
        end
        if (o_done) begin
          check("op_pending_at_done", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("done_time", cyc - fs_cyc, e.s + e.fault + 1);
            check("err", o_err, e.err);
            check("fill_addr", o_fa, e.addr);
            check("busy_at_done", o_busy, 1);
            check("fill_start_pulses", fs_count, 1);
            check("mac_clr_pulses", clr_count, 1);
            check("mac_clr_time", clr_cyc - fs_cyc, -1);
            check("reads_of_empty", ebad, 0);
            for (int j = 0; j <= cur_nr; j++) begin
              off = (j == cur_nr) ? 0 : j;
              check($sformatf("reads[%0d]", j), reads[j], e.reads[j]);
              if (e.reads[j] > 0) begin
                check($sformatf("rden_first[%0d]", j), first[j], e.s + off);
                check($sformatf("rden_last[%0d]", j), last[j], e.s + off + e.reads[j] - 1);
              end
            end
            for (int i = 0; i < cur_nr; i++) begin
              check($sformatf("mac_en_count[%0d]", i), mcnt[i], e.reads[i]);
              if (e.reads[i] > 0) begin
                check($sformatf("mac_en_first[%0d]", i), mfirst[i], e.s + i + 1);
                check($sformatf("mac_en_last[%0d]", i), mlast[i], e.s + i + e.reads[i]);
              end
            end
          end
          clear_acc();
        end
      end
    end
  end

  // One operation: model the expected result, start, act as fill engine,
  // optionally poke start while busy or reset mid-COMPUTE.
  task automatic run_op(input logic [31:0] addr, input int d, input bit stale,
                        input bit poke, input bit rst_mid);
    exp_t e;
    int   fault, off, r, s, t;
    bit   got;
    fault = cur_nr + cur_vl - 1;
    for (int j = 0; j <= cur_nr; j++) begin
      off = (j == cur_nr) ? 0 : j;
      if (n_load[j] < cur_vl && off + n_load[j] < fault) fault = off + n_load[j];
    end
    s = stale ? 13 : ((d < 2) ? 2 : d) + 1;
    t = stale ? 12 : d;
    e = '0;
    e.err = (fault < cur_nr + cur_vl - 1);
    e.addr = addr;
    e.s = 8'(s);
    e.fault = 8'(fault);
    for (int j = 0; j <= cur_nr; j++) begin
      off = (j == cur_nr) ? 0 : j;
      r = fault - off;
      if (r < 0) r = 0;
      if (r > cur_vl) r = cur_vl;
      e.reads[j] = 8'(r);
    end
    if (!rst_mid) exp_q.push_back(e);

    @(posedge clk); #1;
    start_cmd = 1'b1; base_addr = addr;
    if (stale) fill_done = 1'b1;
    @(posedge clk); #1;
    start_cmd = 1'b0;
    @(negedge clk);
    check("err_cleared_on_start", o_err, 0);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (o_fs) got = 1'b1;
      else @(negedge clk);
    end
    check("fill_start_seen", got, 1);
    if (!stale) fill_done = 1'b0;
    for (int k = 1; k <= t; k++) begin
      @(posedge clk); #1;
      start_cmd = poke && (k == 1);
      base_addr = (poke && k == 1) ? ~addr : addr;
      if (stale && k == 2) fill_done = 1'b0;
      if (k == t) begin load_seq++; fill_done = 1'b1; end
    end

    if (rst_mid) begin
      repeat (5) @(posedge clk);
      #2;
      check("rden_b_before_reset", o_rden[cur_nr], 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      got = 1'b0;
      for (int k = 0; k < 120 && !got; k++) begin
        @(negedge clk);
        if (o_done) got = 1'b1;
      end
      check("done_seen", got, 1);
      @(negedge clk);
      check("busy_after_done", o_busy, 0);
      check("done_single_cycle", o_done, 0);
      if (e.err) check("err_sticky", o_err, 1);
    end
  endtask

  task automatic fill_all();
    for (int j = 0; j < 9; j++) n_load[j] = cur_vl;
  endtask

  task automatic random_ops(input int count);
    for (int i = 0; i < count; i++) begin
      fill_all();
      if ($urandom_range(0, 2) == 0)
        n_load[$urandom_range(0, cur_nr)] = int'($urandom_range(0, cur_vl - 1));
      run_op($urandom, int'($urandom_range(1, 25)), $urandom_range(0, 4) == 0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk); #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Nominal 8x8 with a 20-cycle fill.
    fill_all();  run_op(32'h1000_0000, 20, 1'b0, 1'b0, 1'b0);
    // Stale fill_done level must be blanked.
    fill_all();  run_op(32'h1000_0100, 0, 1'b1, 1'b0, 1'b0);
    // Row FIFO 3 runs dry at COMPUTE count 5.
    fill_all();  n_load[3] = 2;  run_op(32'h2000_0000, 6, 1'b0, 1'b0, 1'b0);
    // Following start clears err.
    fill_all();  run_op(32'h2000_0040, 4, 1'b0, 1'b0, 1'b0);
    // Start pulsed while busy is ignored.
    fill_all();  run_op(32'h3000_0000, 8, 1'b0, 1'b1, 1'b0);
    // Vector FIFO empty from the outset.
    fill_all();  n_load[8] = 0;  run_op(32'h3000_0080, 1, 1'b0, 1'b0, 1'b0);
    // Async reset mid-COMPUTE, then a clean run.
    fill_all();  run_op(32'h4000_0000, 5, 1'b0, 1'b0, 1'b1);
    fill_all();  run_op(32'h4000_0100, 3, 1'b0, 1'b0, 1'b0);
    random_ops(20);

    // Small 2x3 configuration.
    sel = 1'b1; cur_nr = 2; cur_vl = 3;
    @(posedge clk); #1;
    fill_all();  run_op(32'h5000_0000, 4, 1'b0, 1'b0, 1'b0);
    fill_all();  n_load[1] = 1;  run_op(32'h5000_0010, 2, 1'b0, 1'b0, 1'b0);
    random_ops(10);

    repeat (4) @(posedge clk);
    check("ops_left_unfinished", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mvm_sequencer.md
Name: mvm_sequencer

Overview:
- Top-level controller for the matrix-vector multiply datapath.
- On start, it clears the MAC array and commands the FIFO-fill engine to load the row FIFOs and the vector FIFO from memory. It then issues skewed (systolic) FIFO read enables and MAC enables, and reports done or underflow error.
- Sits between the user/host control, the fill engine, the NUM_ROWS+1 data FIFOs and the MAC chain.

Parameters:
NUM_ROWS, 8, number of matrix rows / MAC units / A-FIFOs
VEC_LEN, 8, elements per row and per vector (FIFO entries consumed per FIFO)
ADDR_WIDTH, 32, memory address width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin operation; sampled only in IDLE
base_addr  input  ADDR_WIDTH  memory base address; latched on accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at operation end (success or error)
err  output  1  sticky underflow flag; cleared on next accepted start
fill_start  output  1  one-cycle pulse to fill engine
fill_addr  output  ADDR_WIDTH  latched base_addr, held stable from fill_start to fill completion
fill_done  input  1  level from fill engine; high when fill complete
fifo_empty  input  NUM_ROWS+1  bit i<NUM_ROWS = A-FIFO i empty; bit NUM_ROWS = B (vector) FIFO empty
fifo_rden  output  NUM_ROWS+1  read enables, same bit mapping; read data valid 1 cycle later
mac_clr  output  1  synchronous clear of all accumulators
mac_en  output  NUM_ROWS  per-MAC accumulate enable

Behaviour:
- Reset values: busy=0, done=0, err=0, fill_start=0, fill_addr=0, fifo_rden=0, mac_clr=0, mac_en=0; state=IDLE, cnt=0.
- States: IDLE, CLEAR, FILL, WAIT_FILL, COMPUTE, DRAIN, FINISH.
- IDLE:
  - start=1 -> latch base_addr into fill_addr, clear err, go to CLEAR.
  - start in any other state is ignored; no queuing.
- CLEAR: mac_clr=1 for exactly one cycle -> FILL.
- FILL: fill_start=1 for exactly one cycle -> WAIT_FILL.
- WAIT_FILL:
  - fill_done is ignored in the first WAIT_FILL cycle. This blanks a stale level left over from the previous operation.
  - From the second cycle on, fill_done=1 -> COMPUTE with cnt=0. No timeout.
- COMPUTE:
  - cnt runs 0 .. VEC_LEN+NUM_ROWS-2. Width is clog2(VEC_LEN+NUM_ROWS).
  - fifo_rden[NUM_ROWS] = (cnt < VEC_LEN).
  - fifo_rden[i] = (cnt >= i) && (cnt < i+VEC_LEN).
  - fifo_rden is combinational from state and cnt.
  - mac_en[i] = fifo_rden[i] registered by one cycle. It is 0 on the cycle after leaving COMPUTE unless still generated by DRAIN.
  - cnt == VEC_LEN+NUM_ROWS-2 -> DRAIN.
- Underflow:
  - Any cycle in COMPUTE where fifo_rden[k]=1 and fifo_empty[k]=1 sets err.
  - That cycle's fifo_rden is forced to 0.
  - Go to FINISH immediately; mac_en is not asserted for the faulting cycle.
- DRAIN: one cycle; mac_en carries the final registered enable (row NUM_ROWS-1) -> FINISH.
- FINISH: done=1 for one cycle -> IDLE. busy drops in the same cycle the state becomes IDLE.
- Totals:
  - COMPUTE lasts exactly VEC_LEN+NUM_ROWS-1 cycles.
  - Each FIFO is read exactly VEC_LEN times per successful operation.
  - MAC i sees exactly VEC_LEN enables, skewed i cycles after the B FIFO.
- Reset mid-operation: all outputs return to reset values asynchronously. Partially consumed FIFOs are not the sequencer's responsibility.
- fill_addr holds its value after the operation until the next accepted start.

Decomposition:
- Package mvm_pkg holds:
  - state enum typedef (mvm_state_t)
  - localparam CNT_W = $clog2(VEC_LEN+NUM_ROWS)
  - B_IDX = NUM_ROWS
- One sub-module, mvm_skew_gen: takes cnt and active, produces the combinational fifo_rden vector and the registered mac_en. Parameterised by NUM_ROWS and VEC_LEN.
- The FSM, latches and error logic stay in mvm_sequencer.

Test Plan:
- Nominal, defaults, fill_done asserted 20 cycles after fill_start, no empties -> fifo_rden[8] high COMPUTE cycles 0-7; fifo_rden[7] cycles 7-14; mac_en[0] cycles 1-8; mac_en[7] cycles 8-15; done pulses 2 cycles after COMPUTE end; err=0.
- Stale fill_done: fill_done tied high before start and dropped 1 cycle after fill_start, reasserted 10 cycles later -> COMPUTE begins only after the reassertion, not in the first WAIT_FILL cycle.
- Underflow: fifo_empty[3]=1 at COMPUTE cnt=5 -> fifo_rden all 0 that cycle, err=1, done pulse next cycle; next start clears err.
- Start while busy: pulse start during WAIT_FILL with a different base_addr -> ignored; fill_addr unchanged; single done.
- Async reset at COMPUTE cnt=4 -> all outputs 0 immediately; subsequent start runs full nominal sequence.
- NUM_ROWS=2, VEC_LEN=3 -> COMPUTE 4 cycles; rden[2] cycles 0-2, rden[0] 0-2, rden[1] 1-3; exactly 3 mac_en pulses per MAC.
